// File: rtl/alu_4bit_if.sv
// ---------------------------------------------------------------------------
// alu_4bit_if
//
// Bundles the operand/command inputs and the registered result outputs of
// alu_4bit. The master side drives operands and reads results; the slave
// side (the ALU) does the opposite. Clock and reset are not part of the
// bundle and stay as plain ports on the ALU.
//
//   A, B      [WIDTH-1:0]  operands                (master -> slave)
//   ALU_Sel   [2:0]        operation select        (master -> slave)
//   in_valid               capture enable          (master -> slave)
//   ALU_Out   [WIDTH-1:0]  registered result       (slave -> master)
//   CarryOut               carry / borrow flag     (slave -> master)
//   Zero                   ALU_Out == 0            (slave -> master)
//   Overflow               signed overflow flag    (slave -> master)
//   out_valid              result produced last edge (slave -> master)
// ---------------------------------------------------------------------------
interface alu_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALU_Sel;
    logic             in_valid;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;
    logic             Zero;
    logic             Overflow;
    logic             out_valid;

    modport master (
        output A, B, ALU_Sel, in_valid,
        input  ALU_Out, CarryOut, Zero, Overflow, out_valid
    );

    modport slave (
        input  A, B, ALU_Sel, in_valid,
        output ALU_Out, CarryOut, Zero, Overflow, out_valid
    );
endinterface

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------------------
// alu_4bit
//
// Registered ALU with eight operations. The operation result and its flags
// are computed combinationally from the bus inputs and captured on the
// rising edge of clk when in_valid is high, giving one cycle of latency.
// When in_valid is low the result and flags hold and out_valid drops.
//
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   alu_4bit_if slave port (A, B, ALU_Sel, in_valid in;
//         ALU_Out, CarryOut, Zero, Overflow, out_valid out)
//
// Operations (ALU_Sel): ADD, SUB, AND, OR, XOR, NOT A, INC A, DEC A.
// CarryOut is the carry for ADD/INC and the borrow for SUB/DEC.
// ---------------------------------------------------------------------------
module alu_4bit #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_4bit_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    // One extended by a bit so INC/DEC share the carry-out extraction of ADD/SUB.
    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             ovf_next;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;

    assign a_msb = bus.A[MSB];
    assign b_msb = bus.B[MSB];
    assign r_msb = res_next[MSB];

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        sum_ext    = '0;
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;

        case (op_e'(bus.ALU_Sel))
            OP_ADD: begin
                sum_ext    = {1'b0, bus.A} + {1'b0, bus.B};
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            OP_SUB: begin
                // Unsigned wrap of the extended difference sets the top bit
                // exactly when A < B, which is the borrow.
                sum_ext    = {1'b0, bus.A} - {1'b0, bus.B};
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            OP_AND: res_next = bus.A & bus.B;
            OP_OR:  res_next = bus.A | bus.B;
            OP_XOR: res_next = bus.A ^ bus.B;
            OP_NOT: res_next = ~bus.A;
            OP_INC: begin
                sum_ext    = {1'b0, bus.A} + ONE_EXT;
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            OP_DEC: begin
                sum_ext    = {1'b0, bus.A} - ONE_EXT;
                res_next   = sum_ext[WIDTH-1:0];
                carry_next = sum_ext[WIDTH];
            end
            default: ;
        endcase

        // Signed overflow: the result sign disagrees with what the operand
        // signs imply. INC/DEC behave as ADD/SUB with a positive B of 1.
        case (op_e'(bus.ALU_Sel))
            OP_ADD:  ovf_next = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  ovf_next = (a_msb != b_msb) && (r_msb != a_msb);
            OP_INC:  ovf_next = !a_msb && r_msb;
            OP_DEC:  ovf_next = a_msb && !r_msb;
            default: ovf_next = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;
    logic             out_valid_q;

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Zero resets high so it stays consistent with the cleared result.
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                alu_out_q <= res_next;
                carry_q   <= carry_next;
                zero_q    <= (res_next == '0);
                ovf_q     <= ovf_next;
            end
        end
    end

    assign bus.ALU_Out   = alu_out_q;
    assign bus.CarryOut  = carry_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// ---------------------------------------------------------------------------
// tb_alu_4bit
//
// Self-checking bench for alu_4bit. Inputs are driven on the falling edge;
// each accepted input pushes its expected result onto a scoreboard queue,
// and the entry is popped and compared one rising edge later.
// ---------------------------------------------------------------------------
module tb_alu_4bit;

    localparam int WIDTH = 4;

    typedef struct {
        string      tag;
        logic [3:0] out;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;

    alu_4bit_if #(.WIDTH(WIDTH)) bus ();

    alu_4bit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    exp_t last;
    int   n_vec  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer arithmetic, not bit tricks.
    function automatic exp_t model(input string tag, input logic [2:0] op,
                                   input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int ua, ub, sa, sb_i, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb_i = b[3] ? ub - 16 : ub;
        r = 0;
        sr = 0;
        e.tag = tag;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; e.c = (r > 15); sr = sa + sb_i; end
            3'd1: begin r = ua - ub; e.c = (ua < ub); sr = sa - sb_i; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = 15 - ua;
            3'd6: begin r = ua + 1; e.c = (ua == 15); sr = sa + 1; end
            default: begin r = ua - 1; e.c = (ua == 0); sr = sa - 1; end
        endcase
        if (op == 3'd0 || op == 3'd1 || op == 3'd6 || op == 3'd7)
            e.v = (sr > 7) || (sr < -8);
        e.out = 4'(r & 15);
        e.z = (e.out == 4'd0);
        return e;
    endfunction

    function automatic exp_t reset_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.out = 4'd0;
        e.c = 1'b0;
        e.z = 1'b1;
        e.v = 1'b0;
        return e;
    endfunction

    // Compare all outputs against e; out_valid against ov.
    task automatic compare(input exp_t e, input logic ov);
        n_vec++;
        if (bus.out_valid !== ov) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", e.tag, bus.out_valid, ov);
        end
        n_vec++;
        if (bus.ALU_Out !== e.out) begin
            n_fail++;
            $display("FAIL %s ALU_Out: got %b expected %b", e.tag, bus.ALU_Out, e.out);
        end
        n_vec++;
        if (bus.CarryOut !== e.c) begin
            n_fail++;
            $display("FAIL %s CarryOut: got %b expected %b", e.tag, bus.CarryOut, e.c);
        end
        n_vec++;
        if (bus.Zero !== e.z) begin
            n_fail++;
            $display("FAIL %s Zero: got %b expected %b", e.tag, bus.Zero, e.z);
        end
        n_vec++;
        if (bus.Overflow !== e.v) begin
            n_fail++;
            $display("FAIL %s Overflow: got %b expected %b", e.tag, bus.Overflow, e.v);
        end
    endtask

    // One rising edge later: pop a result if one is pending, else expect hold.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last = e;
            compare(e, 1'b1);
        end else begin
            e = last;
            e.tag = {last.tag, "/hold"};
            compare(e, 1'b0);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.ALU_Sel = op;
        bus.in_valid = 1'b1;
    endtask

    task automatic apply(input string tag, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        drive(op, a, b);
        sb.push_back(model(tag, op, a, b));
        step();
    endtask

    task automatic apply_exp(input string tag, input logic [2:0] op,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] out, input logic c,
                             input logic z, input logic v);
        exp_t e;
        e.tag = tag; e.out = out; e.c = c; e.z = z; e.v = v;
        drive(op, a, b);
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.A = 4'($urandom_range(0, 15));
            bus.B = 4'($urandom_range(0, 15));
            bus.ALU_Sel = 3'($urandom_range(0, 7));
            step();
        end
    endtask

    task automatic test_reset();
        bus.A = '0;
        bus.B = '0;
        bus.ALU_Sel = '0;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;          // between edges: must clear without a clock
        #1;
        last = reset_exp("reset");
        compare(last, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_sweep();
        apply_exp("sweep_add", 3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1);
        apply_exp("sweep_sub", 3'b001, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_and", 3'b010, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_or",  3'b011, 4'b0101, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_xor", 3'b100, 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_not", 3'b101, 4'b0101, 4'b0011, 4'b1010, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_inc", 3'b110, 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0, 1'b0);
        apply_exp("sweep_dec", 3'b111, 4'b0101, 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_carry();
        apply_exp("add_carry", 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        apply_exp("sub_borrow", 3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0);
        apply_exp("inc_wrap", 3'b110, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        apply_exp("dec_wrap", 3'b111, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        apply_exp("add_ovf", 3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1);
        apply_exp("sub_ovf", 3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1);
        apply_exp("inc_ovf", 3'b110, 4'b0111, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1);
        apply_exp("dec_ovf", 3'b111, 4'b1000, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b1);
        // Negative-operand cases that must not overflow, and one that must.
        apply_exp("add_neg", 3'b000, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0);
        apply_exp("add_negovf", 3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1);
        apply_exp("sub_posovf", 3'b001, 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_enable();
        apply("en_pre", 3'b011, 4'b1001, 4'b0100);
        idle(3);
        apply("en_post", 3'b100, 4'b1100, 4'b1010);
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [3:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            apply($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), op, a, b);
            if ((i % 9) == 8) idle(1);
        end
    endtask

    task automatic test_reset_midstream();
        apply("mid_a", 3'b000, 4'b0010, 4'b0011);
        apply("mid_b", 3'b001, 4'b1001, 4'b0100);
        // Accepted input whose result must be discarded by reset.
        drive(3'b101, 4'b0110, 4'b0000);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        last = reset_exp("mid_reset");
        compare(last, 1'b0);
        @(negedge clk);
        compare(last, 1'b0);
        rst = 1'b0;
        bus.A = 4'b1011;
        bus.B = 4'b0110;
        bus.ALU_Sel = 3'b000;
        sb.push_back(model("mid_after", 3'b000, 4'b1011, 4'b0110));
        step();
        apply("mid_after2", 3'b111, 4'b0001, 4'b0000);
        idle(1);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_carry();
        test_overflow();
        test_enable();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
